transistor_sweeper: RTL and testbench
=====================================

Name: transistor_sweeper

Overview:
Synthesizable stimulus/check engine, the driving end of the transistor-pair interface. It steps the supply and gate inputs of a transistor model (vdd, gate in; p-out, n-out back) through all four input combinations. It waits a programmable settle time at each step, samples both outputs, and compares them against expected truth tables. It replaces ad-hoc delay-based stimulus with a clocked, self-checking sweep usable in simulation or on hardware.

Parameters:
SETTLE, 4, cycles each step is driven before sampling (legal range 1..255).
EXP_P, 4'b0100, expected p-out, indexed by {vdd,gate}. Default is the ideal p switch: p = vdd & ~gate.
EXP_N, 4'b1000, expected n-out, indexed by {vdd,gate}. Default is the ideal n switch: n = vdd & gate.

Ports:
pin_clk  in  1  clock; all state changes on the rising edge
pin_rst  in  1  synchronous reset, active-high
pin_start  in  1  begin sweep; honoured only in IDLE
pin_abort  in  1  cancel a sweep in progress
pin_p_in  in  1  p-out of the transistor model
pin_n_in  in  1  n-out of the transistor model
pin_vdd_drv  out  1  registered vdd drive to the model
pin_gate_drv  out  1  registered gate drive to the model
pin_busy  out  1  high while a sweep is in progress
pin_done  out  1  one-cycle pulse when a sweep completes
pin_pass  out  1  sweep result; valid from the done pulse until the next start
pin_fail_mask  out  4  bit s set if step s mismatched
pin_capture  out  8  sampled outputs; [2s+1] is p and [2s] is n for step s
pin_step  out  2  current step index

Behaviour:
- Reset (pin_rst=1 at an edge): state=IDLE. All outputs 0: drives, busy, done, pass, fail_mask, capture, step, settle counter.
- Step sequence is Gray order, one input changing per step. Step 0 = {vdd,gate} 00, step 1 = 10, step 2 = 11, step 3 = 01.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - Drives held at 00.
  - If start=1 and abort=0 at an edge: go to DRIVE with step=0, counter=0, busy=1, drives = step-0 combo. Clear fail_mask, capture and pass at the same edge.
- DRIVE:
  - Counter increments each cycle.
  - When counter==SETTLE-1 at an edge, go to SAMPLE.
  - DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - At its closing edge, register p_in and n_in into capture[2s+1:2s].
  - Set fail_mask[s] if p_in≠EXP_P[combo] or n_in≠EXP_N[combo].
  - If s<3: go to DRIVE with s+1, counter=0, drives updated to the new combo at that same edge.
  - If s==3: go to DONE.
- DONE (1 cycle):
  - done=1 and busy=0; drives return to 00.
  - pass = (final fail_mask==0), including the step-3 result.
  - Next state is IDLE.
- Latency: with the start edge as edge 0, step s samples at edge (s+1)(SETTLE+1). Done is high in the cycle after edge 4(SETTLE+1).
- Outputs (pass, fail_mask, capture) hold until the next accepted start.
- start while busy or in DONE is ignored; no queuing.
- abort=1 at any edge in DRIVE or SAMPLE:
  - Go to IDLE with drives 00 and busy=0.
  - No done pulse; pass=0.
  - fail_mask and capture keep the steps completed so far; the step in progress is not sampled.
- abort and start in the same cycle in IDLE: abort wins and the sweep does not start.
- Reset mid-sweep: same as the reset case, with all outputs cleared.
- Inputs are sampled directly; no synchronizers, since the model is synchronous to pin_clk.

Test Plan:
- Default parameters, ideal model, start pulse at edge 0 -> drives sequence 00,10,11,01 each held 5 cycles; done at cycle 20; capture=8'h18, fail_mask=0, pass=1.
- n_in stuck at 0 -> fail_mask=4'b0100, capture=8'h08, pass=0, done at cycle 20.
- SETTLE=1 -> each step lasts 2 cycles; done at cycle 8; same values as the ideal-model case.
- Abort asserted during step 2 DRIVE -> busy drops next edge, no done pulse, drives=00, capture[3:0]=4'b1000, pass=0. A new start then runs a full passing sweep.
- Start re-pulsed while busy, and start+abort together in IDLE -> no effect on sequence or timing; the second case never leaves IDLE.
- pin_rst asserted during step 1 -> all outputs 0 at the next edge; FSM back in IDLE and accepts a start.

Source files
------------

// File: rtl/transistor_sweeper.sv
// Clocked stimulus/check engine for a transistor-pair model: steps {vdd,gate}
// through all four combinations in Gray order, samples p/n and scores them.
module transistor_sweeper #(
  parameter int unsigned SETTLE = 4,
  parameter logic [3:0]  EXP_P  = 4'b0100,
  parameter logic [3:0]  EXP_N  = 4'b1000
) (
  input  logic       pin_clk,
  input  logic       pin_rst,
  input  logic       pin_start,
  input  logic       pin_abort,
  input  logic       pin_p_in,
  input  logic       pin_n_in,
  output logic       pin_vdd_drv,
  output logic       pin_gate_drv,
  output logic       pin_busy,
  output logic       pin_done,
  output logic       pin_pass,
  output logic [3:0] pin_fail_mask,
  output logic [7:0] pin_capture,
  output logic [1:0] pin_step
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(SETTLE - 1);

  state_t     r_state;
  logic [7:0] r_count;
  logic [1:0] r_step;
  logic       r_vdd;
  logic       r_gate;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_failMask;
  logic [7:0] r_capture;

  logic [1:0] w_combo;
  logic [1:0] w_nextCombo;
  logic       w_mismatch;
  logic [3:0] w_failNext;
  logic [7:0] w_captureNext;

  // Gray order 00,10,11,01: vdd = s1^s0, gate = s1.
  function automatic logic [1:0] stepCombo(input logic [1:0] s);
    return {s[1] ^ s[0], s[1]};
  endfunction

  always_comb begin
    w_combo       = stepCombo(r_step);
    w_nextCombo   = stepCombo(r_step + 2'd1);
    w_mismatch    = (pin_p_in != EXP_P[w_combo]) || (pin_n_in != EXP_N[w_combo]);
    w_failNext    = r_failMask;
    w_failNext[r_step] = w_mismatch;
    w_captureNext = r_capture;
    w_captureNext[{r_step, 1'b0} +: 2] = {pin_p_in, pin_n_in};
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      r_state    <= IDLE;
      r_count    <= 8'd0;
      r_step     <= 2'd0;
      r_vdd      <= 1'b0;
      r_gate     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_failMask <= 4'd0;
      r_capture  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_vdd  <= 1'b0;
          r_gate <= 1'b0;
          if (pin_start && !pin_abort) begin
            r_state    <= DRIVE;
            r_step     <= 2'd0;
            r_count    <= 8'd0;
            r_busy     <= 1'b1;
            {r_vdd, r_gate} <= stepCombo(2'd0);
            r_failMask <= 4'd0;
            r_capture  <= 8'd0;
            r_pass     <= 1'b0;
          end
        end

        DRIVE: begin
          if (pin_abort) begin
            r_state <= IDLE;
            r_vdd   <= 1'b0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_count <= 8'd0;
          end else begin
            r_count <= r_count + 8'd1;
            if (r_count == LAST_COUNT) begin
              r_state <= SAMPLE;
            end
          end
        end

        // An abort here discards the step in progress without sampling it.
        SAMPLE: begin
          if (pin_abort) begin
            r_state <= IDLE;
            r_vdd   <= 1'b0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_count <= 8'd0;
          end else begin
            r_capture  <= w_captureNext;
            r_failMask <= w_failNext;
            if (r_step != 2'd3) begin
              r_state <= DRIVE;
              r_step  <= r_step + 2'd1;
              r_count <= 8'd0;
              {r_vdd, r_gate} <= w_nextCombo;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_vdd   <= 1'b0;
              r_gate  <= 1'b0;
              r_pass  <= (w_failNext == 4'd0);
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pin_vdd_drv   = r_vdd;
  assign pin_gate_drv  = r_gate;
  assign pin_busy      = r_busy;
  assign pin_done      = r_done;
  assign pin_pass      = r_pass;
  assign pin_fail_mask = r_failMask;
  assign pin_capture   = r_capture;
  assign pin_step      = r_step;

endmodule

// File: tb/tb_transistor_sweeper.sv
// Bench for transistor_sweeper: two instances (SETTLE=4 and SETTLE=1) driving
// a transistor model with injectable faults, scored against a timeline model.
module tb_transistor_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB, startA, startB, abortA, abortB;
  logic [3:0] flipP, flipN;

  logic vddA, gateA, busyA, doneA, passA;
  logic [3:0] maskA;
  logic [7:0] capA;
  logic [1:0] stepA;
  logic vddB, gateB, busyB, doneB, passB;
  logic [3:0] maskB;
  logic [7:0] capB;
  logic [1:0] stepB;

  // Transistor model: ideal switches with per-combination fault flips.
  logic pA, nA, pB, nB;
  assign pA = (vddA & ~gateA) ^ flipP[{vddA, gateA}];
  assign nA = (vddA &  gateA) ^ flipN[{vddA, gateA}];
  assign pB = (vddB & ~gateB) ^ flipP[{vddB, gateB}];
  assign nB = (vddB &  gateB) ^ flipN[{vddB, gateB}];

  transistor_sweeper dutA (
    .pin_clk(clk), .pin_rst(rstA), .pin_start(startA), .pin_abort(abortA),
    .pin_p_in(pA), .pin_n_in(nA), .pin_vdd_drv(vddA), .pin_gate_drv(gateA),
    .pin_busy(busyA), .pin_done(doneA), .pin_pass(passA),
    .pin_fail_mask(maskA), .pin_capture(capA), .pin_step(stepA)
  );

  transistor_sweeper #(.SETTLE(1)) dutB (
    .pin_clk(clk), .pin_rst(rstB), .pin_start(startB), .pin_abort(abortB),
    .pin_p_in(pB), .pin_n_in(nB), .pin_vdd_drv(vddB), .pin_gate_drv(gateB),
    .pin_busy(busyB), .pin_done(doneB), .pin_pass(passB),
    .pin_fail_mask(maskB), .pin_capture(capB), .pin_step(stepB)
  );

  int testCount = 0;
  int failCount = 0;

  function automatic logic [1:0] comboOf(input int s);
    case (s)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [7:0] expCap(input int n);
    logic [7:0] c;
    logic [1:0] cb;
    c = 8'd0;
    for (int s = 0; s < n; s++) begin
      cb = comboOf(s);
      c[2*s+1] = (cb == 2'b10) ^ flipP[cb];
      c[2*s]   = (cb == 2'b11) ^ flipN[cb];
    end
    return c;
  endfunction

  function automatic logic [3:0] expMask(input int n);
    logic [3:0] m;
    logic [1:0] cb;
    m = 4'd0;
    for (int s = 0; s < n; s++) begin
      cb = comboOf(s);
      m[s] = flipP[cb] | flipN[cb];
    end
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input int sel, input string ctx, input logic [1:0] drv,
                          input logic busy, input logic done, input logic pass,
                          input logic [3:0] mask, input logic [7:0] cap, input int stepE);
    logic [1:0] oDrv, oStep;
    logic oBusy, oDone, oPass;
    logic [3:0] oMask;
    logic [7:0] oCap;
    oDrv  = sel != 0 ? {vddB, gateB} : {vddA, gateA};
    oBusy = sel != 0 ? busyB : busyA;
    oDone = sel != 0 ? doneB : doneA;
    oPass = sel != 0 ? passB : passA;
    oMask = sel != 0 ? maskB : maskA;
    oCap  = sel != 0 ? capB  : capA;
    oStep = sel != 0 ? stepB : stepA;
    checkOutput({ctx, " drv"},  32'(oDrv),  32'(drv));
    checkOutput({ctx, " busy"}, 32'(oBusy), 32'(busy));
    checkOutput({ctx, " done"}, 32'(oDone), 32'(done));
    checkOutput({ctx, " pass"}, 32'(oPass), 32'(pass));
    checkOutput({ctx, " mask"}, 32'(oMask), 32'(mask));
    checkOutput({ctx, " cap"},  32'(oCap),  32'(cap));
    if (stepE >= 0) checkOutput({ctx, " step"}, 32'(oStep), 32'(stepE));
  endtask

  task automatic applyStimulus(input int sel, input logic start, input logic abort);
    if (sel != 0) begin startB = start; abortB = abort; end
    else          begin startA = start; abortA = abort; end
  endtask

  task automatic setReset(input int sel, input logic v);
    if (sel != 0) rstB = v; else rstA = v;
  endtask

  // stopKind: 0 = run to completion, 1 = abort, 2 = reset; the stop is
  // driven after edge stopAt and therefore acts at edge stopAt+1.
  task automatic runSweep(input int sel, input int settle, input int stopAt,
                          input int stopKind, input bit repulse, input string ctx);
    int T, s, n;
    logic finalPass;
    T = 4 * (settle + 1);
    finalPass = (expMask(4) == 4'd0);
    @(negedge clk);
    applyStimulus(sel, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(sel, 1'b0, 1'b0);
    for (int k = 0; k <= T + 1; k++) begin
      if (stopKind == 1 && k == stopAt + 1) begin
        n = stopAt / (settle + 1);
        applyStimulus(sel, 1'b0, 1'b0);
        checkAll(sel, {ctx, " aborted"}, 2'b00, 1'b0, 1'b0, 1'b0, expMask(n), expCap(n), -1);
        for (int j = 0; j < T; j++) begin
          @(negedge clk);
          checkAll(sel, {ctx, " post-abort"}, 2'b00, 1'b0, 1'b0, 1'b0, expMask(n), expCap(n), -1);
        end
        break;
      end
      if (stopKind == 2 && k == stopAt + 1) begin
        checkAll(sel, {ctx, " reset"}, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 0);
        setReset(sel, 1'b0);
        break;
      end
      if (k < T) begin
        s = k / (settle + 1);
        checkAll(sel, {ctx, " run"}, comboOf(s), 1'b1, 1'b0, 1'b0, expMask(s), expCap(s), s);
      end else if (k == T) begin
        checkAll(sel, {ctx, " done"}, 2'b00, 1'b0, 1'b1, finalPass, expMask(4), expCap(4), -1);
      end else begin
        checkAll(sel, {ctx, " hold"}, 2'b00, 1'b0, 1'b0, finalPass, expMask(4), expCap(4), -1);
      end
      applyStimulus(sel, repulse && (k < T) && (k % 3 == 1), stopKind == 1 && k == stopAt);
      if (stopKind == 2 && k == stopAt) setReset(sel, 1'b1);
      @(negedge clk);
    end
    applyStimulus(sel, 1'b0, 1'b0);
  endtask

  initial begin
    int sel, settle, kind, stopAt;
    rstA = 1'b1; rstB = 1'b1;
    startA = 1'b0; startB = 1'b0; abortA = 1'b0; abortB = 1'b0;
    flipP = 4'd0; flipN = 4'd0;
    repeat (2) @(negedge clk);
    checkAll(0, "resetA", 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 0);
    checkAll(1, "resetB", 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 0);
    rstA = 1'b0; rstB = 1'b0;

    runSweep(0, 4, -1, 0, 1'b0, "idealA");
    checkOutput("idealA capture", 32'(capA), 32'h18);

    applyStimulus(0, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkAll(0, "startAbortIdle", 2'b00, 1'b0, 1'b0, 1'b1, 4'd0, 8'h18, -1);
    end
    applyStimulus(0, 1'b0, 1'b0);

    flipN = 4'b1000;
    runSweep(0, 4, -1, 0, 1'b0, "stuckN");
    checkOutput("stuckN mask", 32'(maskA), 32'h4);
    checkOutput("stuckN capture", 32'(capA), 32'h08);
    flipN = 4'd0;

    runSweep(1, 1, -1, 0, 1'b0, "settle1");
    checkOutput("settle1 capture", 32'(capB), 32'h18);

    runSweep(0, 4, 11, 1, 1'b0, "abortStep2");
    checkOutput("abortStep2 cap low", 32'(capA[3:0]), 32'h8);
    runSweep(0, 4, -1, 0, 1'b0, "afterAbort");

    runSweep(0, 4, -1, 0, 1'b1, "repulse");

    runSweep(0, 4, 6, 2, 1'b0, "resetStep1");
    runSweep(0, 4, -1, 0, 1'b0, "afterReset");

    for (int r = 0; r < 8; r++) begin
      flipP  = 4'($urandom);
      flipN  = 4'($urandom);
      sel    = int'($urandom_range(0, 1));
      settle = (sel != 0) ? 1 : 4;
      kind   = int'($urandom_range(0, 1));
      stopAt = int'($urandom_range(0, 4 * (settle + 1) - 1));
      runSweep(sel, settle, stopAt, kind, r[0], "random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
